// File: rtl/data_memory_pkg.sv
// Shared MEM command encodings, MMIO register offsets and lane helpers for data_memory.
// The sys_defs-style macros are defined here once so every file sees identical values.
`ifndef DM_SYS_DEFS_VH
`define DM_SYS_DEFS_VH
`define MEM_NONE        4'h0
`define MEM_LB          4'h1
`define MEM_LH          4'h2
`define MEM_LW          4'h3
`define MEM_LBU         4'h4
`define MEM_LHU         4'h5
`define MEM_SB          4'h6
`define MEM_SH          4'h7
`define MEM_SW          4'h8
`define DM_CYCLE_LO_OFS 4'h0
`define DM_CYCLE_HI_OFS 4'h4
`define DM_TOHOST_OFS   4'h8
`define DM_HALT_OFS     4'hC
`define DM_MMIO_BASE    32'hFFFF_0000
`endif

package data_memory_pkg;

    typedef enum logic [3:0] {
        CMD_NONE = `MEM_NONE,
        CMD_LB   = `MEM_LB,
        CMD_LH   = `MEM_LH,
        CMD_LW   = `MEM_LW,
        CMD_LBU  = `MEM_LBU,
        CMD_LHU  = `MEM_LHU,
        CMD_SB   = `MEM_SB,
        CMD_SH   = `MEM_SH,
        CMD_SW   = `MEM_SW
    } mem_cmd_e;

    // Word select inside the 16-byte MMIO window (addr[3:2]).
    typedef enum logic [1:0] {
        REG_CYCLE_LO = 2'(`DM_CYCLE_LO_OFS >> 2),
        REG_CYCLE_HI = 2'(`DM_CYCLE_HI_OFS >> 2),
        REG_TOHOST   = 2'(`DM_TOHOST_OFS >> 2),
        REG_HALT     = 2'(`DM_HALT_OFS >> 2)
    } mmio_reg_e;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/dm_lane_ctrl.sv
// Combinational lane logic: misalignment check, byte enables, store replication,
// and load lane select with sign/zero extension.
module dm_lane_ctrl
    import data_memory_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [3:0]  cmd,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic        misaligned,
    output logic [3:0]  byte_en,
    output logic [31:0] write_data,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted = load_word >> {offset, 3'b000};

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        misaligned = 1'b0;
        byte_en    = 4'b0000;
        write_data = store_data;
        load_data  = 32'h0;

        unique case (mem_cmd_e'(cmd))
            CMD_LB:  load_data = sext8(shifted[7:0]);
            CMD_LBU: load_data = {24'h0, shifted[7:0]};
            CMD_LH: begin
                misaligned = offset[0];
                load_data  = sext16(shifted[15:0]);
            end
            CMD_LHU: begin
                misaligned = offset[0];
                load_data  = {16'h0, shifted[15:0]};
            end
            CMD_LW: begin
                misaligned = (offset != 2'b00);
                load_data  = load_word;
            end
            CMD_SB: begin
                byte_en    = 4'b0001 << offset;
                write_data = {4{store_data[7:0]}};
            end
            CMD_SH: begin
                misaligned = offset[0];
                byte_en    = 4'b0011 << offset;
                write_data = {2{store_data[15:0]}};
            end
            CMD_SW: begin
                misaligned = (offset != 2'b00);
                byte_en    = 4'b1111;
            end
            default: ;
        endcase

        // A misaligned access neither writes nor returns data.
        if (misaligned) begin
            byte_en   = 4'b0000;
            load_data = 32'h0;
        end
    end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with lane steering and an optional MMIO window
// (cycle counter, TOHOST, HALT) enabled by defining DM_MMIO_EN.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = `DM_MMIO_BASE,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MEM_mem_addr,
    input  logic [3:0]  MEM_mem_cmd,
    input  logic [31:0] MEM_mem_din,
    output logic [31:0] DM_mem_dout,
    output logic        DM_misaligned,
    output logic        DM_err,
    output logic [31:0] DM_tohost,
    output logic        DM_tohost_vld,
    output logic        DM_halt
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      ram [DEPTH_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic             mmio_hit;
    logic [31:0]      mmio_word;
    logic [31:0]      read_word;
    logic [3:0]       byte_en;
    logic [31:0]      write_data;
    logic [31:0]      load_data;
    logic             ram_we;

    assign word_idx = MEM_mem_addr[IDX_W+1:2];

    dm_lane_ctrl u_lane_ctrl (
        .offset     (MEM_mem_addr[1:0]),
        .cmd        (MEM_mem_cmd),
        .store_data (MEM_mem_din),
        .load_word  (read_word),
        .misaligned (DM_misaligned),
        .byte_en    (byte_en),
        .write_data (write_data),
        .load_data  (load_data)
    );

    assign read_word   = mmio_hit ? mmio_word : ram[word_idx];
    assign DM_mem_dout = load_data;
    assign ram_we      = rst && !mmio_hit && (byte_en != 4'b0000);

    // NOTE: the RAM array has no reset; its contents survive rst and a reset port would block RAM inference.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) ram[word_idx][8*b +: 8] <= write_data[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) DM_err <= 1'b0;
        else if (DM_misaligned) DM_err <= 1'b1;
    end

`ifdef DM_MMIO_EN
    logic [63:0] cycle_cnt;
    logic        sw_aligned;
    logic        tohost_we;
    logic        halt_we;

    assign mmio_hit   = (MEM_mem_addr[31:4] == MMIO_BASE[31:4]);
    assign sw_aligned = (mem_cmd_e'(MEM_mem_cmd) == CMD_SW) && !DM_misaligned;
    assign tohost_we  = mmio_hit && sw_aligned && (mmio_reg_e'(MEM_mem_addr[3:2]) == REG_TOHOST);
    assign halt_we    = mmio_hit && sw_aligned && (mmio_reg_e'(MEM_mem_addr[3:2]) == REG_HALT);

    always_comb begin
        mmio_word = 32'h0;
        unique case (mmio_reg_e'(MEM_mem_addr[3:2]))
            REG_CYCLE_LO: mmio_word = cycle_cnt[31:0];
            REG_CYCLE_HI: mmio_word = cycle_cnt[63:32];
            REG_TOHOST:   mmio_word = DM_tohost;
            REG_HALT:     mmio_word = {31'h0, DM_halt};
            default:      mmio_word = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt     <= 64'h0;
            DM_tohost     <= 32'h0;
            DM_tohost_vld <= 1'b0;
            DM_halt       <= 1'b0;
        end else begin
            cycle_cnt     <= cycle_cnt + 64'h1;
            DM_tohost_vld <= tohost_we;
            if (tohost_we) DM_tohost <= MEM_mem_din;
            if (halt_we && (MEM_mem_din != 32'h0)) DM_halt <= 1'b1;
        end
    end
`else
    logic unused_addr_bits;

    assign mmio_hit         = 1'b0;
    assign mmio_word        = 32'h0;
    assign DM_tohost        = 32'h0;
    assign DM_tohost_vld    = 1'b0;
    assign DM_halt          = 1'b0;
    assign unused_addr_bits = ^MEM_mem_addr[31:IDX_W+2];
`endif

endmodule
